// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary pointer conversion and pointer width rule.
// Used by the read controller; the optional FIFO_RD_LEVEL_EN build also uses gray2bin.
package fifo_pkg;

  localparam int unsigned FN_W         = 32;
  localparam int unsigned DEF_ADDR_W   = 4;
  localparam int unsigned DEF_DATA_W   = 32;

  // Pointers carry one extra wrap bit above the memory address.
  function automatic int unsigned ptr_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b = g;
    for (int i = 1; i < int'(FN_W); i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the async FIFO: synchronized write pointer, memory port and consumer handshake.
// rlevel exists only when FIFO_RD_LEVEL_EN is defined.
interface fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_W,
  parameter int unsigned DATA_WIDTH = DEF_DATA_W
);

  localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);

  logic [PTR_W-1:0]      rq2_wptr;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [PTR_W-1:0]      rptr;
  logic                  rempty;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdout;
`ifdef FIFO_RD_LEVEL_EN
  logic [PTR_W-1:0]      rlevel;
`endif

  modport master (
    input  rq2_wptr,
    input  rdata,
    input  rready,
    output raddr,
    output rptr,
    output rempty,
    output rvalid,
    output rdout
`ifdef FIFO_RD_LEVEL_EN
    ,
    output rlevel
`endif
  );

  modport slave (
    output rq2_wptr,
    output rdata,
    output rready,
    input  raddr,
    input  rptr,
    input  rempty,
    input  rvalid,
    input  rdout
`ifdef FIFO_RD_LEVEL_EN
    ,
    input  rlevel
`endif
  );

endinterface

// File: rtl/fifo_out_reg.sv
// First-word-fall-through output register: holds one word under a valid/ready handshake.
module fifo_out_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  rready,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdout
);

  // A load wins over a drain so the register refills in the cycle it empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdout  <= '0;
    end else if (load) begin
      rvalid <= 1'b1;
      rdout  <= din;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: binary/Gray read pointer, registered empty flag, FWFT output.
// Defining FIFO_RD_LEVEL_EN adds the registered rlevel occupancy output.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_W,
  parameter int unsigned DATA_WIDTH = DEF_DATA_W
) (
  input  logic           rclk,
  input  logic           rrst_n,
  fifo_rd_ctrl_if.master bus
);

  localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rptr_q;
  logic             rempty_q;
  logic             rvalid_int;
  logic             rinc_c;
  logic [PTR_W-1:0] rbin_next_c;
  logic [PTR_W-1:0] rgray_next_c;

  // Read only when memory has data and the output slot is free or being drained.
  assign rinc_c       = ~rempty_q & (~rvalid_int | bus.rready);
  assign rbin_next_c  = rbin + PTR_W'(rinc_c);
  assign rgray_next_c = PTR_W'(bin2gray(FN_W'(rbin_next_c)));

  // Empty compares the next Gray pointer so the flag is exact the cycle after a read.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin     <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
    end else begin
      rbin     <= rbin_next_c;
      rptr_q   <= rgray_next_c;
      rempty_q <= (rgray_next_c == bus.rq2_wptr);
    end
  end

  fifo_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk    (rclk),
    .rst_n  (rrst_n),
    .load   (rinc_c),
    .rready (bus.rready),
    .din    (bus.rdata),
    .rvalid (rvalid_int),
    .rdout  (bus.rdout)
  );

  assign bus.raddr  = rbin[ADDR_WIDTH-1:0];
  assign bus.rptr   = rptr_q;
  assign bus.rempty = rempty_q;
  assign bus.rvalid = rvalid_int;

`ifdef FIFO_RD_LEVEL_EN
  logic [PTR_W-1:0] wbin_c;
  logic [PTR_W-1:0] rlevel_q;

  // Words still in memory; the word parked in rdout is not counted.
  assign wbin_c = PTR_W'(gray2bin(FN_W'(bus.rq2_wptr)));

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rlevel_q <= '0;
    end else begin
      rlevel_q <= wbin_c - rbin;
    end
  end

  assign bus.rlevel = rlevel_q;
`endif

endmodule
